// File: rtl/uart_tx_frame_gen_if.sv
// Write-side FIFO port of the UART frame transmitter: push strobe/data and queue status.
interface uart_tx_frame_gen_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) ();
  logic                          wr_en;
  logic [DATA_BITS-1:0]          wr_data;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow
  );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART frame transmitter: write FIFO feeding a gap/start/data/parity/stop serialiser.
// Every bit is exactly CLKS_PER_BIT cycles; tx, busy and frame_done are registered.
module uart_tx_frame_gen #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_frame_gen_if.slave wr,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned MaxBits = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
  localparam int unsigned BitW    = $clog2(MaxBits);

  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudPen  = CntW'(CLKS_PER_BIT - 2);
  localparam logic [BitW-1:0] GapLast  = BitW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic            ParityOdd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StGap, StStart, StData, StParity, StStop} state_e;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 overflow_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_e               state_q;
  logic [CntW-1:0]      baud_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 baud_last;

  assign wr.full     = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign wr.empty    = (count_q == '0);
  assign wr.level    = count_q;
  assign wr.overflow = overflow_q;
  assign head        = mem[rd_ptr_q];
  assign baud_last   = (baud_q == BaudLast);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign push = wr.wr_en && (!wr.full || pop);

  always_comb begin
    pop = 1'b0;
    if (!wr.empty) begin
      if (state_q == StIdle) begin
        pop = 1'b1;
      end else if (state_q == StStop && baud_last && bit_q == StopLast) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr.wr_en && wr.full && !pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (pop) begin
            shift_q  <= head;
            parity_q <= (^head) ^ ParityOdd;
            baud_q   <= '0;
            bit_q    <= '0;
            busy     <= 1'b1;
            if (GAP_BITS > 0) begin
              state_q <= StGap;
            end else begin
              state_q <= StStart;
              tx      <= 1'b0;
            end
          end
        end
        StGap: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == GapLast) begin
              bit_q   <= '0;
              state_q <= StStart;
              tx      <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
            tx      <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == DataLast) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                tx      <= parity_q;
              end else begin
                state_q <= StStop;
                tx      <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StParity: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StStop;
            tx      <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == StopLast) begin
              bit_q <= '0;
              if (pop) begin
                shift_q  <= head;
                parity_q <= (^head) ^ ParityOdd;
                if (GAP_BITS > 0) begin
                  state_q <= StGap;
                end else begin
                  state_q <= StStart;
                  tx      <= 1'b0;
                end
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
            // Raised one cycle early so the registered pulse lands on the final stop cycle.
            frame_done <= (bit_q == StopLast) && (baud_q == BaudPen);
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
